// File: rtl/stepdir_pkg.sv
// Shared definitions for the step/direction pulse generator.
package stepdir_pkg;

  // Smallest legal length of any setup, high or period interval, in cycles.
  localparam int unsigned MIN_CYC_DEF = 3;
  // Width of the interval timers.
  localparam int unsigned TMR_W = 16;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DIR_SETUP  = 2'd1,
    S_PULSE_HIGH = 2'd2,
    S_PULSE_LOW  = 2'd3
  } state_e;

  // Clamped pulse timing captured when a move is accepted.
  typedef struct packed {
    logic [TMR_W-1:0] pw;   // step high cycles
    logic [TMR_W-1:0] per;  // rising-edge-to-rising-edge cycles
  } timing_t;

endpackage

// File: rtl/stepdir_gen_if.sv
// Move request channel: valid/ready handshake carrying direction and step count.
//   move_valid  master -> slave  request present
//   move_ready  slave  -> master block can accept
//   move_dir    master -> slave  1 = forward
//   move_count  master -> slave  steps to emit
interface stepdir_gen_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             move_valid;
  logic             move_ready;
  logic             move_dir;
  logic [CNT_W-1:0] move_count;

  modport master (output move_valid, output move_dir, output move_count, input move_ready);
  modport slave  (input move_valid, input move_dir, input move_count, output move_ready);
endinterface

// File: rtl/stepdir_timer.sv
// Loadable 16-bit down-counter that stops at zero.
//   clk, resetn  clock / async active-low reset
//   load         load load_val this cycle (priority over counting)
//   load_val     value to load
//   zero_c       counter currently holds zero
module stepdir_timer
  import stepdir_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero_c
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TMR_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/stepdir_gen.sv
// Step/direction pulse generator: accepts a move of N steps and emits N step
// pulses with programmable dir setup, high time and period, tracking position.
//   clk, resetn          clock / async active-low reset
//   mv                   move request channel (slave side)
//   config_dir_setup     dir-to-step setup cycles (clamped to MIN_CYC)
//   config_pulse_width   step high cycles (clamped to MIN_CYC)
//   config_step_period   rise-to-rise cycles (clamped to pw + MIN_CYC)
//   abort                terminate the current move
//   step, dir            registered step pulse and direction level
//   busy, done, aborted  status; done is a one-cycle strobe, aborted qualifies it
//   steps_remaining      steps not yet emitted
//   position             signed emitted-step position, wraps
// MIN_CYC must be at least 1.
module stepdir_gen
  import stepdir_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned POS_W   = 32,
  parameter int unsigned MIN_CYC = MIN_CYC_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  stepdir_gen_if.slave     mv,
  input  logic [7:0]       config_dir_setup,
  input  logic [7:0]       config_pulse_width,
  input  logic [15:0]      config_step_period,
  input  logic             abort,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_remaining,
  output logic [POS_W-1:0] position
);

  state_e           state_q, state_d;
  timing_t          tim_q;
  logic             abort_pend_q;

  logic             accept_c, zero_cnt_c, rise_c, abort_fin_c;
  logic             ph_load_c, per_load_c, ph_zero_c, per_zero_c;
  logic [TMR_W-1:0] ph_val_c, per_val_c;
  logic [TMR_W-1:0] ds_c, pw_c, pw_min_c, per_c;
  logic             step_d, done_d, aborted_d, abort_pend_d;

  assign mv.move_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign accept_c      = mv.move_valid && (state_q == S_IDLE);
  assign zero_cnt_c    = (CNT_W'(mv.move_count) == '0);

  // Clamp the raw configuration to the legal minimum intervals.
  assign ds_c     = (TMR_W'(config_dir_setup) > TMR_W'(MIN_CYC)) ? TMR_W'(config_dir_setup) : TMR_W'(MIN_CYC);
  assign pw_c     = (TMR_W'(config_pulse_width) > TMR_W'(MIN_CYC)) ? TMR_W'(config_pulse_width) : TMR_W'(MIN_CYC);
  assign pw_min_c = pw_c + TMR_W'(MIN_CYC);
  assign per_c    = (config_step_period > pw_min_c) ? config_step_period : pw_min_c;

  // Phase timer covers dir setup and step high time; period timer runs from each rise.
  stepdir_timer u_ph_tmr (
    .clk      (clk),
    .resetn   (resetn),
    .load     (ph_load_c),
    .load_val (ph_val_c),
    .zero_c   (ph_zero_c)
  );

  stepdir_timer u_per_tmr (
    .clk      (clk),
    .resetn   (resetn),
    .load     (per_load_c),
    .load_val (per_val_c),
    .zero_c   (per_zero_c)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c && !zero_cnt_c && !abort) state_d = S_DIR_SETUP;
      end
      S_DIR_SETUP: begin
        if (abort)          state_d = S_IDLE;
        else if (ph_zero_c) state_d = S_PULSE_HIGH;
      end
      S_PULSE_HIGH: begin
        // A pending abort only takes effect once the full high time is out.
        if (ph_zero_c) state_d = (abort || abort_pend_q) ? S_IDLE : S_PULSE_LOW;
      end
      S_PULSE_LOW: begin
        if (abort)           state_d = S_IDLE;
        else if (per_zero_c) state_d = (steps_remaining != '0) ? S_PULSE_HIGH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath control.
  always_comb begin
    rise_c       = 1'b0;
    abort_fin_c  = 1'b0;
    ph_load_c    = 1'b0;
    ph_val_c     = '0;
    per_load_c   = 1'b0;
    per_val_c    = '0;
    abort_pend_d = 1'b0;
    aborted_d    = aborted;

    rise_c = ((state_q == S_DIR_SETUP) && !abort && ph_zero_c) ||
             ((state_q == S_PULSE_LOW) && !abort && per_zero_c && (steps_remaining != '0));

    abort_fin_c = (accept_c && abort) ||
                  (((state_q == S_DIR_SETUP) || (state_q == S_PULSE_LOW)) && abort) ||
                  ((state_q == S_PULSE_HIGH) && ph_zero_c && (abort || abort_pend_q));

    ph_load_c  = accept_c || rise_c;
    ph_val_c   = accept_c ? (ds_c - TMR_W'(1)) : (tim_q.pw - TMR_W'(1));
    per_load_c = rise_c;
    per_val_c  = tim_q.per - TMR_W'(1);

    abort_pend_d = (state_q == S_PULSE_HIGH) && !ph_zero_c && (abort_pend_q || abort);

    if (accept_c)         aborted_d = abort;
    else if (abort_fin_c) aborted_d = 1'b1;

    step_d = (state_d == S_PULSE_HIGH);
    // Any arrival in IDLE, including a zero-step or aborted accept.
    done_d = (state_d == S_IDLE) && ((state_q != S_IDLE) || accept_c);
  end

  // Registered outputs and move context.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step            <= 1'b0;
      dir             <= 1'b0;
      done            <= 1'b0;
      aborted         <= 1'b0;
      abort_pend_q    <= 1'b0;
      steps_remaining <= '0;
      position        <= '0;
      tim_q           <= '0;
    end else begin
      step         <= step_d;
      done         <= done_d;
      aborted      <= aborted_d;
      abort_pend_q <= abort_pend_d;
      if (accept_c) begin
        dir             <= mv.move_dir;
        steps_remaining <= CNT_W'(mv.move_count);
        tim_q.pw        <= pw_c;
        tim_q.per       <= per_c;
      end else if (rise_c) begin
        steps_remaining <= steps_remaining - CNT_W'(1);
        position        <= dir ? (position + POS_W'(1)) : (position - POS_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_stepdir_gen.sv
// Directed testbench for stepdir_gen.
module tb_stepdir_gen;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  cfg_ds, cfg_pw;
  logic [15:0] cfg_per;
  logic        abort;
  logic        step, dir, busy, done, aborted;
  logic [15:0] rem;
  logic [31:0] pos;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int rise_t[$];
  int fall_t[$];
  int done_cnt = 0;
  int done_t   = -1;
  logic step_prev = 1'b0;

  always #5 clk = ~clk;

  stepdir_gen_if #(.CNT_W(16)) mv ();

  stepdir_gen #(.CNT_W(16), .POS_W(32), .MIN_CYC(3)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .mv                 (mv),
    .config_dir_setup   (cfg_ds),
    .config_pulse_width (cfg_pw),
    .config_step_period (cfg_per),
    .abort              (abort),
    .step               (step),
    .dir                (dir),
    .busy               (busy),
    .done               (done),
    .aborted            (aborted),
    .steps_remaining    (rem),
    .position           (pos)
  );

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -100000;
  endfunction

  // Advance one clock, sample 1ns after the edge and log step edges / done.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (step && !step_prev) rise_t.push_back(cyc);
    if (!step && step_prev) fall_t.push_back(cyc);
    step_prev = step;
    if (done) begin
      done_cnt++;
      done_t = cyc;
    end
  endtask

  task automatic clear_log();
    rise_t.delete();
    fall_t.delete();
    done_cnt = 0;
    done_t   = -1;
  endtask

  // Present a move for one cycle; afterwards scramble inputs to show they are latched.
  task automatic start_move(input logic d, input logic [15:0] n, input logic [7:0] ds,
                            input logic [7:0] pw, input logic [15:0] per, input logic ab,
                            output int acc_t);
    clear_log();
    mv.move_dir   = d;
    mv.move_count = n;
    cfg_ds        = ds;
    cfg_pw        = pw;
    cfg_per       = per;
    abort         = ab;
    mv.move_valid = 1'b1;
    tick();
    acc_t         = cyc;
    mv.move_valid = 1'b0;
    abort         = 1'b0;
    mv.move_dir   = ~d;
    mv.move_count = 16'd77;
    cfg_ds        = 8'd200;
    cfg_pw        = 8'd100;
    cfg_per       = 16'd1000;
  endtask

  task automatic wait_done(input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rise(input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (rise_t.size() >= n) break;
      tick();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    chk_cnt++; if (step !== 1'b0) $display("FAIL rst_step got %0b exp 0", step); else pass_cnt++;
    chk_cnt++; if (dir !== 1'b0) $display("FAIL rst_dir got %0b exp 0", dir); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0 || mv.move_ready !== 1'b1) $display("FAIL rst_busy got busy=%0b ready=%0b exp 0/1", busy, mv.move_ready); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0 || aborted !== 1'b0) $display("FAIL rst_done got done=%0b aborted=%0b exp 0/0", done, aborted); else pass_cnt++;
    chk_cnt++; if (rem !== 16'd0 || pos !== 32'd0) $display("FAIL rst_cnt got rem=%0d pos=%0d exp 0/0", rem, pos); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int a; logic ok;
    start_move(1'b1, 16'd3, 8'd5, 8'd4, 16'd20, 1'b0, a);
    chk_cnt++; if (busy !== 1'b1 || dir !== 1'b1) $display("FAIL basic_accept got busy=%0b dir=%0b exp 1/1", busy, dir); else pass_cnt++;
    wait_done(200, ok);
    tick(); tick();
    chk_cnt++; if (ok !== 1'b1) $display("FAIL basic_timeout got done_seen=%0b exp 1", ok); else pass_cnt++;
    chk_cnt++; if (rise_t.size() != 3) $display("FAIL basic_nrise got %0d exp 3", rise_t.size()); else pass_cnt++;
    chk_cnt++; if (at(rise_t, 0) - a != 5) $display("FAIL basic_setup got %0d exp 5", at(rise_t, 0) - a); else pass_cnt++;
    chk_cnt++; if (at(fall_t, 0) - at(rise_t, 0) != 4) $display("FAIL basic_pw0 got %0d exp 4", at(fall_t, 0) - at(rise_t, 0)); else pass_cnt++;
    chk_cnt++; if (at(fall_t, 2) - at(rise_t, 2) != 4) $display("FAIL basic_pw2 got %0d exp 4", at(fall_t, 2) - at(rise_t, 2)); else pass_cnt++;
    chk_cnt++; if (at(rise_t, 1) - at(rise_t, 0) != 20) $display("FAIL basic_per01 got %0d exp 20", at(rise_t, 1) - at(rise_t, 0)); else pass_cnt++;
    chk_cnt++; if (at(rise_t, 2) - at(rise_t, 1) != 20) $display("FAIL basic_per12 got %0d exp 20", at(rise_t, 2) - at(rise_t, 1)); else pass_cnt++;
    chk_cnt++; if (done_t - at(rise_t, 2) != 20) $display("FAIL basic_done_time got %0d exp 20", done_t - at(rise_t, 2)); else pass_cnt++;
    chk_cnt++; if (done_cnt != 1) $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); else pass_cnt++;
    chk_cnt++; if (pos !== 32'd3 || rem !== 16'd0) $display("FAIL basic_pos got pos=%0d rem=%0d exp 3/0", pos, rem); else pass_cnt++;
    chk_cnt++; if (aborted !== 1'b0 || dir !== 1'b1 || busy !== 1'b0) $display("FAIL basic_end got aborted=%0b dir=%0b busy=%0b exp 0/1/0", aborted, dir, busy); else pass_cnt++;
  endtask

  task automatic test_abort_high();
    int a; logic ok;
    start_move(1'b1, 16'd3, 8'd3, 8'd6, 16'd20, 1'b0, a);
    wait_rise(1, 50);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(50, ok);
    tick(); tick();
    chk_cnt++; if (ok !== 1'b1) $display("FAIL abh_timeout got done_seen=%0b exp 1", ok); else pass_cnt++;
    chk_cnt++; if (at(fall_t, 0) - at(rise_t, 0) != 6) $display("FAIL abh_high got %0d exp 6", at(fall_t, 0) - at(rise_t, 0)); else pass_cnt++;
    chk_cnt++; if (done_t != at(fall_t, 0)) $display("FAIL abh_done_time got %0d exp %0d", done_t, at(fall_t, 0)); else pass_cnt++;
    chk_cnt++; if (rise_t.size() != 1 || done_cnt != 1) $display("FAIL abh_counts got rises=%0d dones=%0d exp 1/1", rise_t.size(), done_cnt); else pass_cnt++;
    chk_cnt++; if (aborted !== 1'b1 || busy !== 1'b0) $display("FAIL abh_status got aborted=%0b busy=%0b exp 1/0", aborted, busy); else pass_cnt++;
    chk_cnt++; if (rem !== 16'd2 || pos !== 32'd4) $display("FAIL abh_pos got rem=%0d pos=%0d exp 2/4", rem, pos); else pass_cnt++;
  endtask

  task automatic test_clamp();
    int a; logic ok;
    start_move(1'b1, 16'd2, 8'd0, 8'd0, 16'd2, 1'b0, a);
    chk_cnt++; if (aborted !== 1'b0) $display("FAIL clamp_aborted_clr got %0b exp 0", aborted); else pass_cnt++;
    wait_done(100, ok);
    tick();
    chk_cnt++; if (ok !== 1'b1 || rise_t.size() != 2) $display("FAIL clamp_count got done_seen=%0b rises=%0d exp 1/2", ok, rise_t.size()); else pass_cnt++;
    chk_cnt++; if (at(rise_t, 0) - a != 3) $display("FAIL clamp_setup got %0d exp 3", at(rise_t, 0) - a); else pass_cnt++;
    chk_cnt++; if (at(fall_t, 0) - at(rise_t, 0) != 3) $display("FAIL clamp_pw got %0d exp 3", at(fall_t, 0) - at(rise_t, 0)); else pass_cnt++;
    chk_cnt++; if (at(rise_t, 1) - at(rise_t, 0) != 6) $display("FAIL clamp_per got %0d exp 6", at(rise_t, 1) - at(rise_t, 0)); else pass_cnt++;
    chk_cnt++; if (done_t - at(rise_t, 1) != 6) $display("FAIL clamp_done_time got %0d exp 6", done_t - at(rise_t, 1)); else pass_cnt++;
    chk_cnt++; if (pos !== 32'd6) $display("FAIL clamp_pos got %0d exp 6", pos); else pass_cnt++;
  endtask

  task automatic test_zero_count();
    int a;
    start_move(1'b0, 16'd0, 8'd5, 8'd5, 16'd20, 1'b0, a);
    chk_cnt++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done got done=%0b busy=%0b exp 1/0", done, busy); else pass_cnt++;
    tick();
    chk_cnt++; if (done !== 1'b0) $display("FAIL zero_done_width got %0b exp 0", done); else pass_cnt++;
    repeat (10) tick();
    chk_cnt++; if (rise_t.size() != 0 || done_cnt != 1) $display("FAIL zero_edges got rises=%0d dones=%0d exp 0/1", rise_t.size(), done_cnt); else pass_cnt++;
    chk_cnt++; if (aborted !== 1'b0 || pos !== 32'd6 || dir !== 1'b0) $display("FAIL zero_state got aborted=%0b pos=%0d dir=%0b exp 0/6/0", aborted, pos, dir); else pass_cnt++;
  endtask

  task automatic test_idle_abort();
    clear_log();
    abort = 1'b1;
    repeat (3) tick();
    abort = 1'b0;
    tick();
    chk_cnt++; if (done_cnt != 0 || busy !== 1'b0 || aborted !== 1'b0) $display("FAIL idle_abort got dones=%0d busy=%0b aborted=%0b exp 0/0/0", done_cnt, busy, aborted); else pass_cnt++;
  endtask

  task automatic test_abort_setup();
    int a;
    start_move(1'b1, 16'd4, 8'd10, 8'd3, 16'd20, 1'b0, a);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (15) tick();
    chk_cnt++; if (done_t != a + 3 || done_cnt != 1) $display("FAIL abs_done got t=%0d n=%0d exp %0d/1", done_t, done_cnt, a + 3); else pass_cnt++;
    chk_cnt++; if (rise_t.size() != 0) $display("FAIL abs_nrise got %0d exp 0", rise_t.size()); else pass_cnt++;
    chk_cnt++; if (aborted !== 1'b1 || rem !== 16'd4 || pos !== 32'd6) $display("FAIL abs_state got aborted=%0b rem=%0d pos=%0d exp 1/4/6", aborted, rem, pos); else pass_cnt++;
  endtask

  task automatic test_abort_accept();
    int a;
    start_move(1'b0, 16'd2, 8'd3, 8'd3, 16'd10, 1'b1, a);
    chk_cnt++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL aba_done got done=%0b busy=%0b exp 1/0", done, busy); else pass_cnt++;
    repeat (20) tick();
    chk_cnt++; if (rise_t.size() != 0 || done_cnt != 1 || aborted !== 1'b1) $display("FAIL aba_state got rises=%0d dones=%0d aborted=%0b exp 0/1/1", rise_t.size(), done_cnt, aborted); else pass_cnt++;
    chk_cnt++; if (pos !== 32'd6) $display("FAIL aba_pos got %0d exp 6", pos); else pass_cnt++;
  endtask

  task automatic test_reset_mid_pulse();
    int a;
    start_move(1'b1, 16'd5, 8'd3, 8'd5, 16'd10, 1'b0, a);
    wait_rise(1, 50);
    chk_cnt++; if (step !== 1'b1 || pos !== 32'd7) $display("FAIL rmp_pre got step=%0b pos=%0d exp 1/7", step, pos); else pass_cnt++;
    resetn = 1'b0;
    #1;
    chk_cnt++; if (step !== 1'b0 || dir !== 1'b0 || busy !== 1'b0) $display("FAIL rmp_outs got step=%0b dir=%0b busy=%0b exp 0/0/0", step, dir, busy); else pass_cnt++;
    chk_cnt++; if (pos !== 32'd0 || rem !== 16'd0 || done !== 1'b0 || aborted !== 1'b0) $display("FAIL rmp_cnt got pos=%0d rem=%0d done=%0b aborted=%0b exp 0/0/0/0", pos, rem, done, aborted); else pass_cnt++;
    #3;
    resetn = 1'b1;
    step_prev = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    int a; logic ok;
    start_move(1'b0, 16'd1, 8'd3, 8'd3, 16'd6, 1'b0, a);
    wait_done(50, ok);
    chk_cnt++; if (ok !== 1'b1 || pos !== 32'hFFFF_FFFF) $display("FAIL wrap_down got done_seen=%0b pos=%0h exp 1/ffffffff", ok, pos); else pass_cnt++;
    tick();
    start_move(1'b1, 16'd1, 8'd3, 8'd3, 16'd6, 1'b0, a);
    wait_done(50, ok);
    chk_cnt++; if (ok !== 1'b1 || pos !== 32'd0 || rem !== 16'd0) $display("FAIL wrap_up got done_seen=%0b pos=%0h rem=%0d exp 1/0/0", ok, pos, rem); else pass_cnt++;
  endtask

  initial begin
    mv.move_valid = 1'b0;
    mv.move_dir   = 1'b0;
    mv.move_count = '0;
    cfg_ds        = '0;
    cfg_pw        = '0;
    cfg_per       = '0;
    abort         = 1'b0;
    test_reset();
    test_basic();
    test_abort_high();
    test_clamp();
    test_zero_count();
    test_idle_abort();
    test_abort_setup();
    test_abort_accept();
    test_reset_mid_pulse();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/stepdir_gen.md
STEPDIR_GEN -- requirements
Module: stepdir_gen

Interface
REQ-001 SHALL have parameters: CNT_W, default 16, width of move step count; POS_W, default 32, width of position counter; MIN_CYC, default 3, minimum cycles for any step/dir timing interval.
REQ-002 SHALL have ports: clk  in  1  single system clock, all logic on rising edge.
REQ-003 SHALL have ports: resetn  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: move_valid  in  1  move request present; move_ready  out  1  block can accept a move.
REQ-005 SHALL have ports: move_dir  in  1  1 = forward (receiver increments); move_count  in  CNT_W  steps to emit.
REQ-006 SHALL have ports: config_dir_setup  in  8  dir-to-step setup cycles; config_pulse_width  in  8  step high cycles; config_step_period  in  16  rising-edge-to-rising-edge cycles.
REQ-007 SHALL have ports: abort  in  1  terminate current move; step  out  1  step pulse; dir  out  1  direction level.
REQ-008 SHALL have ports: busy  out  1  move in progress; done  out  1  one-cycle completion strobe; aborted  out  1  qualifies done.
REQ-009 SHALL have ports: steps_remaining  out  CNT_W  steps not yet emitted; position  out  POS_W  signed emitted-step position.

Function
REQ-010 SHALL implement states IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW; move_ready = (state == IDLE); busy = !move_ready.
REQ-011 SHALL accept a move on the cycle move_valid && move_ready; accept latches move_count, move_dir and all three config inputs; later config changes do not affect the move in flight.
REQ-012 SHALL register dir <= move_dir on the accept edge; dir SHALL NOT change at any other time.
REQ-013 SHALL on accept with move_count == 0 stay IDLE, emit no step, and pulse done (aborted = 0) the following cycle.
REQ-014 SHALL on accept with move_count != 0 enter DIR_SETUP for ds = max(config_dir_setup, MIN_CYC) cycles, step = 0.
REQ-015 SHALL in PULSE_HIGH drive step = 1 for pw = max(config_pulse_width, MIN_CYC) cycles; position += 1 if dir else -= 1, and steps_remaining -= 1, on the cycle step rises.
REQ-016 SHALL in PULSE_LOW drive step = 0 until per = max(config_step_period, pw + MIN_CYC) cycles have elapsed since the rising edge; then PULSE_HIGH if steps_remaining != 0, else IDLE.
REQ-017 SHALL pulse done for exactly one cycle on the cycle the block returns to IDLE; aborted holds its value until the next accept.
REQ-018 SHALL on abort in DIR_SETUP or PULSE_LOW return to IDLE next cycle with step = 0, done = 1, aborted = 1.
REQ-019 SHALL on abort in PULSE_HIGH complete the full pw high time (no runt pulse), then return to IDLE with done = 1 and aborted = 1, skipping the remaining low time.
REQ-020 SHALL ignore abort in IDLE; abort coincident with accept aborts the new move with zero steps emitted.
REQ-021 SHALL wrap position modulo 2^POS_W in both directions; steps_remaining never underflows.
REQ-022 SHALL drive step and dir from flops (glitch-free outputs).

Reset
REQ-023 SHALL on resetn low, asynchronously: state = IDLE, step = 0, dir = 0, done = 0, aborted = 0, steps_remaining = 0, position = 0, all timers = 0.
REQ-024 SHALL on resetn low mid-pulse force step low immediately; no position update is emitted for an interrupted pulse beyond those already counted.

Structure
REQ-025 SHALL place the state encoding and MIN_CYC default in shared package stepdir_pkg.
REQ-026 SHALL use one sub-module stepdir_timer (16-bit loadable down-counter with zero flag) for the setup, high and period intervals.

Verification
REQ-027 SHALL cover: dir_setup = 5, pw = 4, period = 20, count = 3, dir = 1 -> three step pulses 4 cycles high, rising edges 20 cycles apart, first rise 5 cycles after dir, position = 3, done once.
REQ-028 SHALL cover: pw = 0, dir_setup = 0, period = 2 -> pw clamped to 3, setup 3, period 6.
REQ-029 SHALL cover: count = 0 -> no step edge, done = 1 one cycle after accept, aborted = 0.
REQ-030 SHALL cover: abort on the 2nd cycle of PULSE_HIGH (pw = 6) -> step stays high 6 cycles total, then IDLE, done = 1, aborted = 1, steps_remaining = count - 1.
REQ-031 SHALL cover: position = 0, move dir = 0 with count = 1 -> position = 2^32 - 1; then dir = 1 with count = 1 -> position = 0.
REQ-032 SHALL cover: resetn asserted mid-PULSE_HIGH -> step = 0 with no clock edge, all outputs at reset values.
